// File: rtl/cpu_trace_buffer.sv
// Execution-trace capture for cpu_top: circular record buffer with PC-match trigger,
// post-trigger count, cycle-budget watchdog and an oldest-first valid/ready readout.
module cpu_trace_buffer #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 8,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int CYC_W   = 16,
    parameter int AW      = $clog2(DEPTH),
    parameter int REC_W   = PC_W + INSTR_W + DATA_W + 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sample_en,
    input  logic [PC_W-1:0]    pc,
    input  logic [INSTR_W-1:0] instr,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic               alu_zero,
    input  logic               write_enable,
    input  logic               mem_write,
    input  logic               arm,
    input  logic               abort,
    input  logic               trig_en,
    input  logic [PC_W-1:0]    trig_pc,
    input  logic [AW-1:0]      post_count,
    input  logic [CYC_W-1:0]   max_cycles,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [REC_W-1:0]   rd_data,
    output logic               rd_last,
    output logic               armed,
    output logic               triggered,
    output logic               timeout,
    output logic               done
);
    // Handshake: a record transfers on any rising edge where rd_valid && rd_ready;
    // rd_valid, rd_data and rd_last hold steady until that transfer (or reset/abort).

    typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;

    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    state_t             state, state_next;
    logic [REC_W-1:0]   mem [DEPTH];
    logic [AW-1:0]      wptr, rptr, remaining;
    logic [AW:0]        count, left;
    logic [CYC_W-1:0]   cyc;
    logic [PC_W-1:0]    trig_pc_q;
    logic               trig_en_q;
    logic [AW-1:0]      post_q;
    logic [CYC_W-1:0]   max_q;

    logic               capturing, wr_en, trig_hit, wd_hit, post_end, finish, xfer;
    logic [AW-1:0]      wptr_nx;
    logic [AW:0]        count_nx;

    always_comb begin
        capturing  = (state == ARMED) || (state == POST);
        wr_en      = capturing && sample_en;
        trig_hit   = (state == ARMED) && sample_en && trig_en_q && (pc == trig_pc_q);
        wd_hit     = capturing && (max_q != '0) && (cyc == max_q - CYC_W'(1));
        post_end   = (state == POST) && sample_en && (remaining == AW'(1));
        finish     = wd_hit || post_end || (trig_hit && (post_q == '0));
        wptr_nx    = wptr + AW'(wr_en);
        count_nx   = (wr_en && (count != FULL)) ? count + (AW + 1)'(1) : count;
        xfer       = (state == DONE) && (left != '0) && rd_ready;
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:        if (arm) state_next = ARMED;
                ARMED, POST: begin
                    if (finish)        state_next = DONE;
                    else if (trig_hit) state_next = POST;
                end
                DONE: if ((left == '0) || (xfer && (left == (AW + 1)'(1)))) state_next = IDLE;
                default:     state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (wr_en && !reset && !abort) mem[wptr] <= {pc, instr, alu_result, alu_zero, write_enable, mem_write};
    end

    always_ff @(posedge clk) begin
        if (reset || abort) begin
            wptr      <= '0;
            rptr      <= '0;
            remaining <= '0;
            count     <= '0;
            left      <= '0;
            cyc       <= '0;
            trig_pc_q <= '0;
            trig_en_q <= 1'b0;
            post_q    <= '0;
            max_q     <= '0;
            triggered <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (arm) begin
                    trig_pc_q <= trig_pc;
                    trig_en_q <= trig_en;
                    post_q    <= post_count;
                    max_q     <= max_cycles;
                    count     <= '0;
                    wptr      <= '0;
                    cyc       <= '0;
                    triggered <= 1'b0;
                    timeout   <= 1'b0;
                end
                ARMED, POST: begin
                    cyc   <= cyc + CYC_W'(1);
                    wptr  <= wptr_nx;
                    count <= count_nx;
                    if (trig_hit) triggered <= 1'b1;
                    if (wd_hit)   timeout   <= 1'b1;
                    if (trig_hit)
                        remaining <= post_q;
                    else if ((state == POST) && sample_en)
                        remaining <= remaining - AW'(1);
                    // A full buffer has count==DEPTH, whose low AW bits are 0: rptr lands on wptr.
                    if (finish) begin
                        rptr <= wptr_nx - count_nx[AW-1:0];
                        left <= count_nx;
                    end
                end
                DONE: if (xfer) begin
                    rptr <= rptr + AW'(1);
                    left <= left - (AW + 1)'(1);
                end
                default: ;
            endcase
        end
    end

    assign armed    = capturing;
    assign done     = (state == DONE);
    assign rd_valid = done && (left != '0);
    assign rd_last  = done && (left == (AW + 1)'(1));
    assign rd_data  = rd_valid ? mem[rptr] : '0;

endmodule

// File: doc/cpu_trace_buffer.md
# cpu_trace_buffer

Parametrised, synthesizable execution-trace capture for `cpu_top`. Each qualified cycle it records the CPU's PC, instruction, ALU result and control strobes into a circular buffer. It arms on request and triggers on a PC match, then captures a programmable number of post-trigger samples. A cycle-budget watchdog ends capture if no trigger arrives. The buffer is then drained oldest-first over a valid/ready port, so trace checking moves from simulation-only printing into hardware that benches and on-chip debug both use.

## Interface
- `PC_W`, 8, PC width
- `INSTR_W`, 8, instruction width
- `DATA_W`, 8, ALU result width
- `DEPTH`, 16, trace entries; power of two, ≥2; `AW = $clog2(DEPTH)`
- `CYC_W`, 16, watchdog counter width
- `REC_W`, derived = `PC_W+INSTR_W+DATA_W+3`, record width

Ports:
- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `sample_en` in 1: capture qualifier (CPU step)
- `pc` in PC_W: CPU program counter
- `instr` in INSTR_W: current instruction
- `alu_result` in DATA_W: ALU output
- `alu_zero` in 1: ALU zero flag
- `write_enable` in 1: register-file write strobe
- `mem_write` in 1: RAM write strobe
- `arm` in 1: start capture (pulse)
- `abort` in 1: cancel anything, return to IDLE
- `trig_en` in 1: enable PC-match trigger
- `trig_pc` in PC_W: trigger PC
- `post_count` in AW: post-trigger samples, sampled at arm
- `max_cycles` in CYC_W: watchdog budget, sampled at arm; 0 = disabled
- `rd_valid` out 1: readout record available
- `rd_ready` in 1: consumer accepts record
- `rd_data` out REC_W: `{pc, instr, alu_result, alu_zero, write_enable, mem_write}`
- `rd_last` out 1: final record of the dump
- `armed` out 1: in ARMED or POST
- `triggered` out 1: trigger seen during the current/last capture
- `timeout` out 1: capture ended by the watchdog
- `done` out 1: in DONE (dump pending)

## Operation
- States: IDLE, ARMED, POST, DONE.
- Reset or `abort` leads to IDLE. Pointers, count, flags and all outputs are 0. `abort` beats `arm` when both are asserted, and wins in every state.
- IDLE:
  - `arm` latches `trig_pc`, `trig_en`, `post_count` and `max_cycles`.
  - It clears count, flags, the write pointer and the cycle counter, then moves to ARMED.
  - `arm` outside IDLE is ignored.
- ARMED and POST:
  - Each `sample_en` cycle writes the record at `wptr` and increments `wptr` modulo DEPTH.
  - `count` saturates at DEPTH, so the oldest entries are overwritten.
- Trigger:
  - The trigger fires in ARMED when `sample_en && trig_en && pc==trig_pc`.
  - The triggering record is written and `triggered` is set.
  - If the latched `post_count==0`, the state goes to DONE; otherwise it goes to POST with `remaining=post_count`.
- POST:
  - Each sample decrements `remaining`.
  - The sample written with `remaining==1` moves the state to DONE.
- Watchdog:
  - The cycle counter increments every ARMED/POST cycle, whether or not a sample is taken.
  - If `max_cycles≠0` and the counter equals `max_cycles-1` at an edge, that cycle's sample (if any) is written, `timeout` is set and the state goes to DONE.
  - If a trigger and a timeout occur in the same cycle, both flags are set and the state goes to DONE.
- Entry to DONE sets `rptr = wptr - count` (mod DEPTH) and `left = count`.
- DONE:
  - `rd_valid = (left≠0)`.
  - `rd_data = buf[rptr]`, combinational read.
  - `rd_last = (left==1)`.
  - Each valid&ready transfer advances `rptr` and decrements `left`.
  - After the last transfer, or on entry with `count==0`, the state goes to IDLE.
  - `triggered` and `timeout` hold until the next `arm`, reset or `abort`.

## Timing
- `arm` at edge N puts the block in ARMED from cycle N+1. The first capturable sample is in cycle N+1.
- The state and flag changes caused by the capture event at edge E are visible in cycle E+1.
- `done`, `rd_valid` and the first `rd_data` are available the cycle after the final capture.
- Readout rate is one record per cycle when `rd_ready` is held high. `rd_data` and `rd_last` are stable while `rd_valid && !rd_ready`.
- `rd_valid` never deasserts without a transfer, except on reset or `abort`.
- Outputs are registered state or decode of registered state. The only combinational path is `buf` → `rd_data`.

## Test plan
- **Reset:** assert `reset` 2 cycles with random inputs → all outputs are 0 and a drain yields nothing.
- **Basic trigger:** DEPTH=16, arm with trig_pc=05, post_count=3, max_cycles=0, `pc` = 00,01,… each cycle with `sample_en=1` → `triggered=1`, `done=1`. The dump is 9 records with pc 00..08 in order, `rd_last` on pc 08.
- **Wrap:** trig_pc=1A, post_count=4 → 31 samples. The dump is 16 records with pc 0F..1E.
- **Watchdog:** max_cycles=10 and no match → `timeout=1`, `triggered=0`. The dump is pc 00..09, 10 records.
- **Backpressure:** `rd_ready` pattern 1,0,0,1,… during the basic-trigger dump → no loss or duplication, and `rd_data` is unchanged while stalled.
- **Abort and reset mid-operation:** `abort` in POST, or mid-dump with `arm` in the same cycle → IDLE next cycle with `rd_valid=0` and `arm` ignored. `reset` in ARMED → IDLE with flags cleared.
